im_stream_packer: RTL

- Sits directly downstream of the image source (test pattern generator or sensor front end) in the im_pclk_i domain.
- Consumes the vsync/hsync/valid/8-bit pixel interface and packs 4 pixels into 32-bit words.
- Marks start of frame and end of line, then buffers the words in a small FIFO behind a valid/ready stream output.
- Also reports frame geometry and overflow status for bring-up.

---
 rtl/im_stream_packer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/im_stream_packer.sv
// Packs an 8-bit pixel stream into 32-bit words with start-of-frame / end-of-line
// markers behind a small FWFT FIFO. Optional pattern checker: define IM_PACK_CHECK_EN.
module im_stream_packer #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 12
) (
  input  logic             im_pclk_i,
  input  logic             rst,
  input  logic             im_vsync,
  input  logic             im_hsync,
  input  logic             im_valid,
  input  logic [7:0]       im_din,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] line_cnt,
  output logic             ovf_err,
  input  logic             clr_err,
  output logic [15:0]      pat_err_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DROP       = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_vsync, r_vsync_d, r_valid, r_valid_d;
  logic [7:0]         r_din;
  logic [1:0]         r_k;
  logic [23:0]        r_acc;
  logic               r_stg_vld;
  logic [31:0]        r_stg_data;
  logic               r_sof;
  logic [CNT_W-1:0]   r_pix, r_lines, r_line_len, r_line_cnt;
  logic [15:0]        r_frame_cnt;
  logic               r_ovf;
  logic [33:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_cnt;

  logic               w_fstart, w_fend, w_lend;
  logic               w_push, w_push_last, w_wr, w_pop, w_full, w_ovf;
  logic [31:0]        w_push_data;
  logic [CNT_W-1:0]   w_lines_next;
  logic               w_unused_hsync;

  assign w_unused_hsync = im_hsync;

  assign w_fstart = r_vsync_d & ~r_vsync;
  assign w_fend   = ~r_vsync_d & r_vsync;
  assign w_lend   = r_valid_d & ~r_valid;

  assign w_lines_next = (w_lend && !(&r_lines)) ? r_lines + 1'b1 : r_lines;

  // A staged full word is the last of its line exactly when the line end shows up in the cycle it is written.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 32'd0;
    w_push_last = 1'b0;
    if (r_state == ACTIVE) begin
      if (r_stg_vld) begin
        w_push      = 1'b1;
        w_push_data = r_stg_data;
        w_push_last = w_lend;
      end else if (w_lend && (r_k != 2'd0)) begin
        w_push      = 1'b1;
        w_push_data = {8'd0, r_acc};
        w_push_last = 1'b1;
      end else begin
        w_push = 1'b0;
      end
    end else begin
      w_push = 1'b0;
    end
  end

  assign m_tvalid = |r_cnt;
  assign w_full   = r_cnt[FIFO_AW];
  assign w_pop    = m_tvalid & m_tready;
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_ovf    = w_push & w_full & ~w_pop;

  // Input capture stage and one-cycle-delayed copies for edge detection.
  always_ff @(posedge im_pclk_i or posedge rst) begin
    if (rst) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_valid   <= 1'b0;
      r_valid_d <= 1'b0;
      r_din     <= 8'd0;
    end else begin
      r_vsync   <= im_vsync;
      r_vsync_d <= r_vsync;
      r_valid   <= im_valid;
      r_valid_d <= r_valid;
      r_din     <= im_din;
    end
  end

  // Frame FSM, packer and geometry counters.
  always_ff @(posedge im_pclk_i or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_FRAME;
      r_k         <= 2'd0;
      r_acc       <= 24'd0;
      r_stg_vld   <= 1'b0;
      r_stg_data  <= 32'd0;
      r_sof       <= 1'b0;
      r_pix       <= '0;
      r_lines     <= '0;
      r_line_len  <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= 16'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_stg_vld <= 1'b0;
      if (w_ovf) r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_wr) r_sof <= 1'b0;
      case (r_state)
        WAIT_FRAME, DROP: begin
          if (w_fstart) begin
            r_state <= ACTIVE;
            r_sof   <= 1'b1;
            r_k     <= 2'd0;
            r_acc   <= 24'd0;
            r_pix   <= '0;
            r_lines <= '0;
          end
        end
        ACTIVE: begin
          if (r_valid) begin
            if (!(&r_pix)) r_pix <= r_pix + 1'b1;
            if (r_k == 2'd3) begin
              r_stg_vld  <= 1'b1;
              r_stg_data <= {r_din, r_acc};
              r_acc      <= 24'd0;
            end else begin
              r_acc[{r_k, 3'b000} +: 8] <= r_din;
            end
            r_k <= r_k + 2'd1;
          end
          if (w_lend) begin
            r_k        <= 2'd0;
            r_acc      <= 24'd0;
            r_line_len <= r_pix;
            r_pix      <= '0;
            r_lines    <= w_lines_next;
          end
          if (w_ovf) begin
            r_state <= DROP;
          end else if (w_fend) begin
            r_line_cnt  <= w_lines_next;
            r_lines     <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_sof       <= 1'b1;
          end else if (w_fstart) begin
            r_sof   <= 1'b1;
            r_k     <= 2'd0;
            r_acc   <= 24'd0;
            r_pix   <= '0;
            r_lines <= '0;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  // First-word-fall-through FIFO; storage is reset so the data outputs read zero when empty after reset.
  always_ff @(posedge im_pclk_i or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 34'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {w_push_data, r_sof, w_push_last};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign m_tdata   = r_mem[r_rptr][33:2];
  assign m_tuser   = r_mem[r_rptr][1];
  assign m_tlast   = r_mem[r_rptr][0];
  assign frame_cnt = r_frame_cnt;
  assign line_len  = r_line_len;
  assign line_cnt  = r_line_cnt;
  assign ovf_err   = r_ovf;

`ifdef IM_PACK_CHECK_EN
  logic [7:0]  r_prev;
  logic        r_have_prev;
  logic [15:0] r_pat_cnt;
  logic        w_mis;

  assign w_mis = (r_state == ACTIVE) & r_valid & r_have_prev & (r_din != r_prev + 8'd1);

  // Ramp checker: each pixel after the first of a line must be its predecessor plus one.
  always_ff @(posedge im_pclk_i or posedge rst) begin
    if (rst) begin
      r_prev      <= 8'd0;
      r_have_prev <= 1'b0;
      r_pat_cnt   <= 16'd0;
    end else begin
      if ((r_state == ACTIVE) && r_valid) begin
        r_prev      <= r_din;
        r_have_prev <= 1'b1;
      end else if (w_lend || w_fstart) begin
        r_have_prev <= 1'b0;
      end else begin
        r_have_prev <= r_have_prev;
      end
      if (clr_err) r_pat_cnt <= 16'd0;
      else if (w_mis && !(&r_pat_cnt)) r_pat_cnt <= r_pat_cnt + 16'd1;
      else r_pat_cnt <= r_pat_cnt;
    end
  end

  assign pat_err_cnt = r_pat_cnt;
`else
  assign pat_err_cnt = 16'd0;
`endif

endmodule
